unified_mem_ctrl: RTL and testbench
===================================

// Module: unified_mem_ctrl
// PURPOSE
//   Parametrised successor to the split debug imem/dmem pair. One single-port word RAM serves both
//   instruction fetch and data load/store. Access latency is configurable, and both ports use a
//   ready handshake, so the CPU stalls instead of relying on a half-cycle clock. Arbitration is
//   round-robin, and the data port has byte-enable stores.
// PARAMETERS
//   W          32  data/address width in bits (multiple of 8)
//   DEPTH_LOG2 10  log2 of RAM depth in words
//   LAT        2   cycles from grant to ready pulse (>=1)
// PORTS
//   clk        in   1      single clock, all logic on posedge
//   rst        in   1      synchronous, active-high reset
//   i_req      in   1      fetch request, held until i_ready
//   i_addr     in   W      fetch byte address
//   i_rdata    out  W      fetched word, valid with i_ready, held until next fetch completes
//   i_ready    out  1      one-cycle completion pulse for fetch
//   d_load_en  in   1      load request, held until d_ready
//   d_l_addr   in   W      load byte address
//   d_l_data   out  W      loaded word, valid with d_ready, held until next load completes
//   d_store_en in   1      store request, held until d_ready
//   d_s_addr   in   W      store byte address
//   d_s_data   in   W      store data
//   d_byte_en  in   W/8    store byte lanes, bit k writes bits [8k+7:8k]
//   d_ready    out  1      one-cycle completion pulse for a data transaction
//   stall      out  1      comb: (i_req&~i_ready) | ((d_load_en|d_store_en)&~d_ready)
// BEHAVIOUR
//   Reset
//   - On rst: state=IDLE, last_grant=INST, counter=0.
//   - i_ready=0, d_ready=0, i_rdata=0, d_l_data=0.
//   - RAM contents are not cleared.
//   Addressing
//   - word index = addr[DEPTH_LOG2+1:2]. addr[1:0] and upper bits are ignored, so addresses wrap.
//   FSM states
//   - IDLE: pick a pending op; if any, latch op/addr/data, counter<=LAT-1, go BUSY.
//   - BUSY: decrement counter. At 0: perform the access, pulse the port's ready, go IDLE.
//   Latency and throughput
//   - Op granted at IDLE edge t completes with ready high in cycle t+LAT.
//   - Min spacing between transactions is LAT+1 cycles.
//   Arbitration
//   - Pending ops are fetch, store and load.
//   - If both ports are pending in IDLE, the grant goes to the port not granted last.
//   - last_grant resets to INST, so data wins the first tie.
//   Simultaneous load and store
//   - d_load_en & d_store_en: store is serviced first with no d_ready pulse.
//   - The load follows as the next data grant; d_ready pulses once, at load completion.
//   - Read-after-write returns the new data.
//   Stores
//   - Written in the completion cycle, only lanes with d_byte_en=1. d_byte_en=0 is a legal no-op
//     and still completes.
//   Reads
//   - RAM is sampled in the completion cycle. rdata registers update only on their own port's
//     completion.
//   Withdrawn request
//   - If a request drops mid-BUSY, the transaction still completes: write commits, ready pulses.
//   Reset mid-transaction
//   - Aborts it and no write commits.
//   - Outputs take reset values next cycle.
//   - A request still high after reset is re-arbitrated from IDLE.
// TESTING
//   1 Reset: hold rst 2 cycles with i_req=1 -> i_ready=0, i_rdata=0, stall=1; first i_ready at
//     LAT cycles after grant.
//   2 Store then load, LAT=2: store 0xDEADBEEF @0x40, be=4'hF, then load @0x40 -> d_ready once
//     each, 2 cycles after grant; d_l_data=0xDEADBEEF.
//   3 Byte enable: mem[0x40]=0xDEADBEEF; store 0x11223344, be=4'b0101 -> reload gives 0xDE22BE44.
//   4 Contention: i_req and d_load_en high from reset -> data completes first, then fetch. A held
//     pair alternates D,I,D,I with grants LAT+1 cycles apart.
//   5 Load+store same cycle @0x80 (store 0x5, old 0x9) -> single d_ready; d_l_data=0x5.
//   6 Wrap/mid-reset: store @ (1<<(DEPTH_LOG2+2))+4 lands in word 1. rst in BUSY of a store to
//     0x8 -> mem[0x8] unchanged.

Source files
------------

// File: rtl/unified_mem_ctrl.sv
// Single-port word RAM shared by instruction fetch and data load/store.
// Requests are arbitrated round-robin, and each access completes with a ready pulse after a fixed latency.
module unified_mem_ctrl #(
  parameter int W          = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LAT        = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [W-1:0]    i_addr,
  output logic [W-1:0]    i_rdata,
  output logic            i_ready,
  input  logic            d_load_en,
  input  logic [W-1:0]    d_l_addr,
  output logic [W-1:0]    d_l_data,
  input  logic            d_store_en,
  input  logic [W-1:0]    d_s_addr,
  input  logic [W-1:0]    d_s_data,
  input  logic [W/8-1:0]  d_byte_en,
  output logic            d_ready,
  output logic            stall
);
  localparam int NB    = W / 8;
  localparam int CW    = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;
  typedef enum logic [1:0] {OP_FETCH = 2'd0, OP_LOAD = 2'd1, OP_STORE = 2'd2} op_t;
  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

  logic [W-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  op_t                   op_q, op_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [W-1:0]          wdata_q, wdata_d;
  logic [NB-1:0]         be_q, be_d;
  logic                  last_grant_q, last_grant_d;
  // quiet: store issued on behalf of a load+store pair, so it completes without d_ready
  logic                  quiet_q, quiet_d;
  logic                  store_done_q, store_done_d;
  logic                  i_ready_q, i_ready_d;
  logic                  d_ready_q, d_ready_d;
  logic [W-1:0]          i_rdata_q, i_rdata_d;
  logic [W-1:0]          d_l_data_q, d_l_data_d;
  logic                  mem_we_s;
  logic                  d_pend_s;
  logic                  d_is_store_s;
  logic                  pick_data_s;
  logic [W-1:0]          rd_word_s;

  assign rd_word_s    = mem[addr_q];
  assign d_pend_s     = d_load_en | d_store_en;
  assign d_is_store_s = d_store_en & ~(d_load_en & store_done_q);
  assign pick_data_s  = d_pend_s & (~i_req | (last_grant_q == GRANT_INST));

  // Arbitration, latency countdown and completion of the granted access.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    last_grant_d = last_grant_q;
    quiet_d      = quiet_q;
    store_done_d = store_done_q;
    i_ready_d    = 1'b0;
    d_ready_d    = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_l_data_d   = d_l_data_q;
    mem_we_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_req | d_pend_s) begin
          state_d = S_BUSY;
          cnt_d   = CW'(LAT - 1);
          if (pick_data_s) begin
            last_grant_d = GRANT_DATA;
            if (d_is_store_s) begin
              op_d    = OP_STORE;
              addr_d  = d_s_addr[DEPTH_LOG2+1:2];
              wdata_d = d_s_data;
              be_d    = d_byte_en;
              quiet_d = d_load_en;
            end else begin
              op_d    = OP_LOAD;
              addr_d  = d_l_addr[DEPTH_LOG2+1:2];
              quiet_d = 1'b0;
            end
          end else begin
            last_grant_d = GRANT_INST;
            op_d         = OP_FETCH;
            addr_d       = i_addr[DEPTH_LOG2+1:2];
            quiet_d      = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d = S_IDLE;
          case (op_q)
            OP_FETCH: begin
              i_ready_d = 1'b1;
              i_rdata_d = rd_word_s;
            end
            OP_LOAD: begin
              d_ready_d    = 1'b1;
              d_l_data_d   = rd_word_s;
              store_done_d = 1'b0;
            end
            OP_STORE: begin
              mem_we_s = 1'b1;
              if (quiet_q) begin
                store_done_d = 1'b1;
              end else begin
                d_ready_d    = 1'b1;
                store_done_d = 1'b0;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= OP_FETCH;
      cnt_q        <= {CW{1'b0}};
      addr_q       <= {DEPTH_LOG2{1'b0}};
      wdata_q      <= {W{1'b0}};
      be_q         <= {NB{1'b0}};
      last_grant_q <= GRANT_INST;
      quiet_q      <= 1'b0;
      store_done_q <= 1'b0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      i_rdata_q    <= {W{1'b0}};
      d_l_data_q   <= {W{1'b0}};
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      last_grant_q <= last_grant_d;
      quiet_q      <= quiet_d;
      store_done_q <= store_done_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
      i_rdata_q    <= i_rdata_d;
      d_l_data_q   <= d_l_data_d;
    end
  end

  // Byte-lane RAM write; a reset on the completion edge suppresses the commit.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      for (int k = 0; k < NB; k++) begin
        if (be_q[k]) begin
          mem[addr_q][8*k +: 8] <= wdata_q[8*k +: 8];
        end
      end
    end
  end

  assign i_rdata  = i_rdata_q;
  assign i_ready  = i_ready_q;
  assign d_l_data = d_l_data_q;
  assign d_ready  = d_ready_q;
  assign stall    = (i_req & ~i_ready_q) | (d_pend_s & ~d_ready_q);

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Directed, table-driven bench for unified_mem_ctrl (LAT=2) with hand sequences for
// arbitration, load+store pairing, withdrawn requests and reset during a store.
module tb_unified_mem_ctrl;
  localparam int W   = 32;
  localparam int DL2 = 10;
  localparam int LAT = 2;

  logic          clk, rst;
  logic          i_req, i_ready, d_load_en, d_store_en, d_ready, stall;
  logic [W-1:0]  i_addr, i_rdata, d_l_addr, d_l_data, d_s_addr, d_s_data;
  logic [3:0]    d_byte_en;

  unified_mem_ctrl #(.W(W), .DEPTH_LOG2(DL2), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_load_en(d_load_en), .d_l_addr(d_l_addr), .d_l_data(d_l_data),
    .d_store_en(d_store_en), .d_s_addr(d_s_addr), .d_s_data(d_s_data),
    .d_byte_en(d_byte_en), .d_ready(d_ready), .stall(stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  op;   // 0 fetch, 1 load, 2 store
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [14];
  int   nvec  = 0;
  int   nfail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; d_load_en = 1'b0; d_store_en = 1'b0;
  endtask

  task automatic do_txn(input string name, input vec_t v);
    int n;
    logic seen, other;
    i_addr = v.addr; d_l_addr = v.addr; d_s_addr = v.addr;
    d_s_data = v.wdata; d_byte_en = v.be;
    i_req = (v.op == 2'd0); d_load_en = (v.op == 2'd1); d_store_en = (v.op == 2'd2);
    n = 0; seen = 1'b0; other = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen  = (v.op == 2'd0) ? i_ready : d_ready;
      other = (v.op == 2'd0) ? d_ready : i_ready;
    end
    check({name, "_done"}, {31'd0, seen}, 32'd1);
    check({name, "_lat"}, n, LAT + 1);
    check({name, "_other_rdy"}, {31'd0, other}, 32'd0);
    check({name, "_stall"}, {31'd0, stall}, 32'd0);
    if (v.op == 2'd0) check({name, "_i_rdata"}, i_rdata, v.exp);
    if (v.op == 2'd1) check({name, "_d_l_data"}, d_l_data, v.exp);
    idle_inputs();
    @(negedge clk);
    check({name, "_pulse1"}, {31'd0, (v.op == 2'd0) ? i_ready : d_ready}, 32'd0);
  endtask

  initial begin
    int n, ne, nd;
    int ev_t [4];
    int ev_k [4];
    logic [31:0] ev_d [4];

    vecs[0]  = '{2'd2, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 32'h0};
    vecs[1]  = '{2'd1, 32'h0000_0040, 32'h0,         4'h0, 32'hDEAD_BEEF};
    vecs[2]  = '{2'd2, 32'h0000_0040, 32'h1122_3344, 4'h5, 32'h0};
    vecs[3]  = '{2'd1, 32'h0000_0040, 32'h0,         4'h0, 32'hDE22_BE44};
    vecs[4]  = '{2'd0, 32'h0000_0040, 32'h0,         4'h0, 32'hDE22_BE44};
    vecs[5]  = '{2'd2, 32'h0000_0100, 32'hCAFE_F00D, 4'hF, 32'h0};
    vecs[6]  = '{2'd0, 32'h0000_0100, 32'h0,         4'h0, 32'hCAFE_F00D};
    vecs[7]  = '{2'd2, 32'h0000_0100, 32'hFFFF_FFFF, 4'h0, 32'h0};
    vecs[8]  = '{2'd1, 32'h0000_0100, 32'h0,         4'h0, 32'hCAFE_F00D};
    vecs[9]  = '{2'd2, 32'h0000_1004, 32'hA5A5_A5A5, 4'hF, 32'h0};
    vecs[10] = '{2'd1, 32'h0000_0004, 32'h0,         4'h0, 32'hA5A5_A5A5};
    vecs[11] = '{2'd1, 32'h0000_0006, 32'h0,         4'h0, 32'hA5A5_A5A5};
    vecs[12] = '{2'd2, 32'h0000_0008, 32'h1234_5678, 4'hF, 32'h0};
    vecs[13] = '{2'd1, 32'h0000_0008, 32'h0,         4'h0, 32'h1234_5678};

    i_addr = 32'h40; d_l_addr = 32'h0; d_s_addr = 32'h0; d_s_data = 32'h0; d_byte_en = 4'h0;
    idle_inputs();
    // Reset held two cycles with a pending fetch.
    rst = 1'b1; i_req = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_i_ready", {31'd0, i_ready}, 32'd0);
      check("rst_i_rdata", i_rdata, 32'd0);
      check("rst_d_l_data", d_l_data, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd1);
    end
    rst = 1'b0;
    n = 0;
    while (!i_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_first_fetch_lat", n, LAT + 1);
    idle_inputs();
    @(negedge clk);

    for (int i = 0; i < 14; i++) do_txn($sformatf("vec%0d", i), vecs[i]);
    check("i_rdata_held", i_rdata, 32'hCAFE_F00D);

    // Load and store asserted together at 0x80 (old value 0x9).
    do_txn("ls_pre", '{2'd2, 32'h80, 32'h9, 4'hF, 32'h0});
    d_l_addr = 32'h80; d_s_addr = 32'h80; d_s_data = 32'h5; d_byte_en = 4'hF;
    d_load_en = 1'b1; d_store_en = 1'b1;
    n = 0; nd = 0;
    while (nd == 0 && n < 20) begin
      @(negedge clk);
      n++;
      if (d_ready) nd++;
    end
    idle_inputs();
    check("ls_lat", n, 2 * LAT + 2);
    check("ls_data", d_l_data, 32'h5);
    repeat (4) begin
      @(negedge clk);
      if (d_ready) nd++;
    end
    check("ls_single_ready", nd, 1);

    // Fetch withdrawn right after grant still completes.
    i_addr = 32'h80; i_req = 1'b1;
    @(negedge clk);
    i_req = 1'b0;
    n = 1;
    while (!i_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wd_lat", n, LAT + 1);
    check("wd_data", i_rdata, 32'h5);
    @(negedge clk);

    // Contention from reset: data first, then alternate.
    rst = 1'b1; i_req = 1'b1; i_addr = 32'h40; d_load_en = 1'b1; d_l_addr = 32'h100;
    repeat (2) begin
      @(negedge clk);
      check("cont_rst_stall", {31'd0, stall}, 32'd1);
      check("cont_rst_rdy", {30'd0, i_ready, d_ready}, 32'd0);
    end
    rst = 1'b0;
    ne = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (i_ready && d_ready) check("cont_both_rdy", 32'd1, 32'd0);
      if ((i_ready || d_ready) && ne < 4) begin
        ev_t[ne] = c;
        ev_k[ne] = d_ready ? 1 : 0;
        ev_d[ne] = d_ready ? d_l_data : i_rdata;
        ne++;
      end
    end
    idle_inputs();
    check("cont_events", ne, 4);
    for (int e = 0; e < ne; e++) begin
      check($sformatf("cont_kind%0d", e), ev_k[e], (e % 2 == 0) ? 1 : 0);
      check($sformatf("cont_time%0d", e), ev_t[e], (LAT + 1) * (e + 1));
      check($sformatf("cont_data%0d", e), ev_d[e], (e % 2 == 0) ? 32'hCAFE_F00D : 32'hDE22_BE44);
    end
    repeat (4) @(negedge clk);

    // Reset on the completion edge of a store to 0x8 aborts it.
    d_s_addr = 32'h8; d_s_data = 32'hFFFF_FFFF; d_byte_en = 4'hF; d_store_en = 1'b1;
    repeat (LAT) @(negedge clk);
    rst = 1'b1; d_store_en = 1'b0;
    @(negedge clk);
    check("mrst_d_ready", {31'd0, d_ready}, 32'd0);
    check("mrst_d_l_data", d_l_data, 32'd0);
    check("mrst_i_rdata", i_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    do_txn("mrst_reload", '{2'd1, 32'h8, 32'h0, 4'h0, 32'h1234_5678});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
